// File: rtl/draw_rect_ctl_if.sv
// draw_rect_ctl_if: mouse/frame-sync inputs and rectangle position outputs.
`default_nettype none

interface draw_rect_ctl_if;
  logic        vsync;
  logic        start;
  logic [11:0] xpos_in;
  logic [11:0] ypos_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        busy;

  modport master (
    output vsync, start, xpos_in, ypos_in,
    input  xpos, ypos, busy
  );

  modport slave (
    input  vsync, start, xpos_in, ypos_in,
    output xpos, ypos, busy
  );
endinterface

`default_nettype wire

// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: tracks the mouse in idle, then drops the rectangle with
// per-frame gravity and damped floor bounces. Rev 1.0
`default_nettype none

module draw_rect_ctl #(
  parameter int V_ACTIVE   = 600,
  parameter int RECT_H     = 64,
  parameter int G          = 1,
  parameter int V_MAX      = 63,
  parameter int DAMP_SHIFT = 2,
  parameter int V_MIN      = 2
) (
  input  logic            clk,
  input  logic            rst,
  draw_rect_ctl_if.slave  ctl_bus
);

  localparam logic [11:0] FLOOR = 12'(V_ACTIVE - RECT_H);
  localparam logic [8:0]  G9    = 9'(G);
  localparam logic [7:0]  G8    = 8'(G);
  localparam logic [7:0]  VMAX8 = 8'(V_MAX);
  localparam logic [7:0]  VMIN8 = 8'(V_MIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [7:0]  vel_q, vel_d;
  logic        busy_q;
  logic        vsync_q, start_q;

  logic        tick, press;
  logic [8:0]  vn_sum;
  logic [7:0]  vn, reb;
  logic [12:0] yn;

  assign tick  = ctl_bus.vsync & ~vsync_q;
  assign press = ctl_bus.start & ~start_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      xpos_q  <= '0;
      ypos_q  <= '0;
      vel_q   <= '0;
      busy_q  <= 1'b0;
      vsync_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      vel_q   <= vel_d;
      busy_q  <= (state_d != IDLE);
      vsync_q <= ctl_bus.vsync;
      start_q <= ctl_bus.start;
    end
  end

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    vn_sum  = {1'b0, vel_q} + G9;
    vn      = (vn_sum > {1'b0, VMAX8}) ? VMAX8 : vn_sum[7:0];
    reb     = vn - (vn >> DAMP_SHIFT);
    // One bit wider than ypos so a fast drop near the floor cannot wrap.
    yn      = {1'b0, ypos_q} + {5'd0, vn};

    case (state_q)
      IDLE: begin
        xpos_d = ctl_bus.xpos_in;
        ypos_d = ctl_bus.ypos_in;
        if (press) begin
          ypos_d  = (ctl_bus.ypos_in > FLOOR) ? FLOOR : ctl_bus.ypos_in;
          vel_d   = '0;
          state_d = FALL;
        end
      end
      FALL: begin
        if (tick) begin
          if (yn >= {1'b0, FLOOR}) begin
            ypos_d  = FLOOR;
            vel_d   = reb;
            state_d = (reb < VMIN8) ? DONE : RISE;
          end else begin
            ypos_d = yn[11:0];
            vel_d  = vn;
          end
        end
      end
      RISE: begin
        if (tick) begin
          if (vel_q > G8) begin
            ypos_d = (ypos_q >= {4'd0, vel_q}) ? (ypos_q - {4'd0, vel_q}) : '0;
            vel_d  = vel_q - G8;
          end else begin
            vel_d   = '0;
            state_d = FALL;
          end
        end
      end
      DONE: begin
        if (press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctl_bus.xpos = xpos_q;
  assign ctl_bus.ypos = ypos_q;
  assign ctl_bus.busy = busy_q;

endmodule

`default_nettype wire
